// File: rtl/fall_detect_multistage.sv
// Fall detector: 2-stage |a|^2 pipeline feeding a sample-timed free-fall/impact/stillness FSM.
// Decision 3 edges after the data_valid edge; no backpressure, accepts one sample per clock.
module fall_detect_multistage #(
  parameter int DATA_W           = 16,
  parameter int SAMPLE_RATE_HZ   = 50,
  parameter int FREEFALL_MIN_MS  = 100,
  parameter int IMPACT_WINDOW_MS = 500,
  parameter int STILL_TIME_MS    = 300,
  parameter int COOLDOWN_MS      = 1000,
  parameter int REQUIRE_FREEFALL = 1,
  parameter int CNT_W            = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       data_valid,
  input  logic signed [DATA_W-1:0]   ax,
  input  logic signed [DATA_W-1:0]   ay,
  input  logic signed [DATA_W-1:0]   az,
  input  logic        [2*DATA_W-1:0] freefall_thresh_sq,
  input  logic        [2*DATA_W-1:0] impact_thresh_sq,
  input  logic        [2*DATA_W-1:0] still_thresh_sq,
  input  logic                       alarm_ack,
  output logic                       fall_pulse,
  output logic                       alarm_latched,
  output logic        [CNT_W-1:0]    fall_count,
  output logic        [2*DATA_W-1:0] mag_sq_o,
  output logic                       mag_valid_o,
  output logic        [2:0]          state_o
);

  localparam int MW = 2 * DATA_W;

  localparam int FF_RAW  = (FREEFALL_MIN_MS * SAMPLE_RATE_HZ) / 1000;
  localparam int IMP_RAW = (IMPACT_WINDOW_MS * SAMPLE_RATE_HZ) / 1000;
  localparam int ST_RAW  = (STILL_TIME_MS * SAMPLE_RATE_HZ) / 1000;
  localparam int CD_RAW  = (COOLDOWN_MS * SAMPLE_RATE_HZ) / 1000;
  localparam int FF_N    = (FF_RAW < 1) ? 1 : FF_RAW;
  localparam int IMP_N   = (IMP_RAW < 1) ? 1 : IMP_RAW;
  localparam int STILL_N = (ST_RAW < 1) ? 1 : ST_RAW;
  // A zero cooldown means the confirm goes straight back to IDLE.
  localparam int CD_N    = (COOLDOWN_MS == 0) ? 0 : ((CD_RAW < 1) ? 1 : CD_RAW);

  localparam int MAX_AB = (FF_N > IMP_N) ? FF_N : IMP_N;
  localparam int MAX_CD = (STILL_N > CD_N) ? STILL_N : CD_N;
  localparam int MAX_N  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] FF_NC    = CW'(FF_N);
  localparam logic [CW-1:0] IMP_NC   = CW'(IMP_N);
  localparam logic [CW-1:0] STILL_NC = CW'(STILL_N);
  localparam logic [CW-1:0] CD_NC    = CW'(CD_N);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FREEFALL    = 3'd1,
    S_IMPACT_WAIT = 3'd2,
    S_STILL       = 3'd3,
    S_COOLDOWN    = 3'd4
  } state_e;

  logic signed [MW-1:0] ax_e, ay_e, az_e;
  logic [MW-1:0]        sqx_q, sqy_q, sqz_q;
  logic                 sq_vld_q;
  logic [MW-1:0]        mag_q;
  logic                 mag_vld_q;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 confirm;
  logic                 pulse_q;
  logic                 alarm_q;
  logic [CNT_W-1:0]     count_q;

  assign ax_e = MW'(ax);
  assign ay_e = MW'(ay);
  assign az_e = MW'(az);

  // Sum of three squares tops out at 3*2^(MW-2), so MW bits never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sqx_q     <= '0;
      sqy_q     <= '0;
      sqz_q     <= '0;
      sq_vld_q  <= 1'b0;
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
    end else begin
      sq_vld_q  <= data_valid;
      mag_vld_q <= sq_vld_q;
      if (data_valid) begin
        sqx_q <= $unsigned(ax_e * ax_e);
        sqy_q <= $unsigned(ay_e * ay_e);
        sqz_q <= $unsigned(az_e * az_e);
      end
      if (sq_vld_q) mag_q <= sqx_q + sqy_q + sqz_q;
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    confirm = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (mag_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (REQUIRE_FREEFALL != 0) begin
            if (mag_q < freefall_thresh_sq) begin
              state_d = S_FREEFALL;
              cnt_d   = CW'(1);
            end
          end else if (mag_q > impact_thresh_sq) begin
            state_d = S_STILL;
            cnt_d   = '0;
          end
        end
        S_FREEFALL: begin
          if (mag_q < freefall_thresh_sq) begin
            if (cnt_q < FF_NC) cnt_d = cnt_inc;
          end else if (cnt_q < FF_NC) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (mag_q > impact_thresh_sq) begin
            state_d = S_STILL;
            cnt_d   = '0;
          end else begin
            state_d = S_IMPACT_WAIT;
            cnt_d   = CW'(1);
          end
        end
        S_IMPACT_WAIT: begin
          if (mag_q > impact_thresh_sq) begin
            state_d = S_STILL;
            cnt_d   = '0;
          end else if (cnt_q == IMP_NC) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_STILL: begin
          if (mag_q >= still_thresh_sq) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == STILL_NC) begin
            confirm = 1'b1;
            state_d = (CD_N == 0) ? S_IDLE : S_COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_COOLDOWN: begin
          if (cnt_inc == CD_NC) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      alarm_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= confirm;
      // A confirm on the same edge as an acknowledge keeps the alarm set.
      alarm_q <= confirm | (alarm_q & ~alarm_ack);
      if (confirm && (count_q != {CNT_W{1'b1}})) count_q <= count_q + CNT_W'(1);
    end
  end

  assign fall_pulse    = pulse_q;
  assign alarm_latched = alarm_q;
  assign fall_count    = count_q;
  assign mag_sq_o      = mag_q;
  assign mag_valid_o   = mag_vld_q;
  assign state_o       = state_q;

endmodule
